// File: rtl/conv_engine.sv
// conv_engine: N_CH-lane 2-D convolution engine.
// Image/filter buffers, one-tap-per-cycle MAC, valid/ready result port.
module conv_engine #(
    parameter int IMG_W  = 16,
    parameter int K      = 4,
    parameter int N_CH   = 4,
    parameter int DW     = 8,
    parameter int AW     = 32,
    parameter int STRIDE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_img_en,
    input  logic               load_flt_en,
    input  logic [DW-1:0]      load_data,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_CH*AW-1:0] out_data,
    output logic [7:0]         out_row,
    output logic [7:0]         out_col
);

    localparam int OW   = (IMG_W - K) / STRIDE + 1;
    localparam int NPIX = IMG_W * IMG_W;
    localparam int NTAP = N_CH * K * K;
    localparam int IA   = NPIX > 1 ? $clog2(NPIX) : 1;
    localparam int FA   = NTAP > 1 ? $clog2(NTAP) : 1;
    localparam int TW   = K > 1 ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT,
        S_FIN
    } state_t;

    state_t          state;
    logic [DW-1:0]   img_mem [NPIX];
    logic [DW-1:0]   flt_mem [NTAP];
    logic [IA-1:0]   img_ptr;
    logic [FA-1:0]   flt_ptr;
    logic [TW-1:0]   ti;
    logic [TW-1:0]   tj;
    logic [AW-1:0]   acc [N_CH];
    logic [IA-1:0]   pix_addr;
    logic [DW-1:0]   pix;
    logic [2*DW-1:0] prod [N_CH];
    logic            img_we;
    logic            flt_we;
    logic            last_tap;
    logic            last_pos;

    // image has priority when both enables are high; nothing loads mid-pass
    assign img_we = load_img_en & ~busy;
    assign flt_we = load_flt_en & ~load_img_en & ~busy;

    assign last_tap = (ti == TW'(K - 1)) && (tj == TW'(K - 1));
    assign last_pos = (out_row == 8'(OW - 1)) && (out_col == 8'(OW - 1));

    // storage is written only by loads and needs no reset
    always_ff @(posedge clk) begin
        if (img_we) img_mem[img_ptr] <= load_data;
        if (flt_we) flt_mem[flt_ptr] <= load_data;
    end

    // load pointers advance per accepted word and wrap at buffer end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            img_ptr <= '0;
            flt_ptr <= '0;
        end else begin
            if (img_we) begin
                if (img_ptr == IA'(NPIX - 1)) img_ptr <= '0;
                else img_ptr <= img_ptr + 1'b1;
            end
            if (flt_we) begin
                if (flt_ptr == FA'(NTAP - 1)) flt_ptr <= '0;
                else flt_ptr <= flt_ptr + 1'b1;
            end
        end
    end

    // current tap: one shared pixel, one weight per lane
    always_comb begin
        pix_addr = (IA'(out_row) * IA'(STRIDE) + IA'(ti)) * IA'(IMG_W)
                 + IA'(out_col) * IA'(STRIDE) + IA'(tj);
        pix = img_mem[pix_addr];
        for (int n = 0; n < N_CH; n++) begin
            prod[n] = {{DW{1'b0}}, pix}
                    * {{DW{1'b0}}, flt_mem[FA'(n) * FA'(K * K)
                                           + FA'(ti) * FA'(K)
                                           + FA'(tj)]};
        end
    end

    // pass sequencer: accumulate a window, present it, step position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            ti        <= '0;
            tj        <= '0;
            for (int n = 0; n < N_CH; n++) acc[n] <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_MAC;
                        busy    <= 1'b1;
                        out_row <= '0;
                        out_col <= '0;
                        ti      <= '0;
                        tj      <= '0;
                        for (int n = 0; n < N_CH; n++) acc[n] <= '0;
                    end
                end
                S_MAC: begin
                    for (int n = 0; n < N_CH; n++)
                        acc[n] <= acc[n] + AW'(prod[n]);
                    if (last_tap) begin
                        state <= S_OUT;
                        ti    <= '0;
                        tj    <= '0;
                    end else if (tj == TW'(K - 1)) begin
                        tj <= '0;
                        ti <= ti + 1'b1;
                    end else begin
                        tj <= tj + 1'b1;
                    end
                end
                S_OUT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        for (int n = 0; n < N_CH; n++)
                            out_data[n*AW +: AW] <= acc[n];
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_pos) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= S_MAC;
                            for (int n = 0; n < N_CH; n++) acc[n] <= '0;
                            if (out_col == 8'(OW - 1)) begin
                                out_col <= '0;
                                out_row <= out_row + 1'b1;
                            end else begin
                                out_col <= out_col + 1'b1;
                            end
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_engine.sv
// tb_conv_engine: directed bench for conv_engine.
// Three instances: defaults, STRIDE=2, AW=16.
module tb_conv_engine;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       img_en;
    logic [2:0]       flt_en;
    logic [2:0]       start_v;
    logic [2:0]       rdy;
    logic [2:0][7:0]  ldat;
    logic [2:0]       busy_v;
    logic [2:0]       done_v;
    logic [2:0]       ov_v;
    logic [2:0][7:0]  orow;
    logic [2:0][7:0]  ocol;
    logic [127:0]     od0;
    logic [127:0]     od1;
    logic [63:0]      od2;
    int               n_chk = 0;
    int               n_pass = 0;

    always #5 clk = ~clk;

    conv_engine u_def (
        .clk(clk), .rst(rst),
        .load_img_en(img_en[0]), .load_flt_en(flt_en[0]),
        .load_data(ldat[0]), .start(start_v[0]),
        .busy(busy_v[0]), .done(done_v[0]),
        .out_valid(ov_v[0]), .out_ready(rdy[0]),
        .out_data(od0), .out_row(orow[0]), .out_col(ocol[0])
    );

    conv_engine #(.STRIDE(2)) u_s2 (
        .clk(clk), .rst(rst),
        .load_img_en(img_en[1]), .load_flt_en(flt_en[1]),
        .load_data(ldat[1]), .start(start_v[1]),
        .busy(busy_v[1]), .done(done_v[1]),
        .out_valid(ov_v[1]), .out_ready(rdy[1]),
        .out_data(od1), .out_row(orow[1]), .out_col(ocol[1])
    );

    conv_engine #(.AW(16)) u_aw (
        .clk(clk), .rst(rst),
        .load_img_en(img_en[2]), .load_flt_en(flt_en[2]),
        .load_data(ldat[2]), .start(start_v[2]),
        .busy(busy_v[2]), .done(done_v[2]),
        .out_valid(ov_v[2]), .out_ready(rdy[2]),
        .out_data(od2), .out_row(orow[2]), .out_col(ocol[2])
    );

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input int d, input bit im, input bit fl,
                      input logic [7:0] v);
        img_en[d] = im;
        flt_en[d] = fl;
        ldat[d]   = v;
        tick();
        img_en[d] = 1'b0;
        flt_en[d] = 1'b0;
    endtask

    function automatic longint lane(input int d, input int n);
        case (d)
            0:       return longint'(od0[n*32 +: 32]);
            1:       return longint'(od1[n*32 +: 32]);
            default: return longint'(od2[n*16 +: 16]);
        endcase
    endfunction

    function automatic longint exp_lane(input int d, input int r,
                                        input int c, input int n);
        case (d)
            0:       return longint'(16 * (n + 1));
            1:       return n == 0 ? longint'((32 * r + 2 * c) % 256) : 0;
            default: return 57360;
        endcase
    endfunction

    task automatic run_pass(input int d, input int stall_at,
                            input int rst_at);
        int     ow;
        int     cyc;
        int     dn;
        longint snap [4];
        longint srow;
        longint scol;
        ow = (d == 1) ? 7 : 13;
        dn = 0;
        start_v[d] = 1'b1;
        tick();
        start_v[d] = 1'b0;
        chk("busy_after_start", longint'(busy_v[d]), 1);
        for (int k = 0; k < ow * ow; k++) begin
            cyc = 0;
            while (!ov_v[d] && cyc < 100) begin
                tick();
                cyc++;
                dn += int'(done_v[d]);
                if (k == rst_at && cyc == 5) begin
                    rst = 1'b1;
                    tick();
                    chk("rst_busy", longint'(busy_v[d]), 0);
                    chk("rst_valid", longint'(ov_v[d]), 0);
                    chk("rst_row", longint'(orow[d]), 0);
                    chk("rst_col", longint'(ocol[d]), 0);
                    chk("rst_lane0", lane(d, 0), 0);
                    rst = 1'b0;
                    tick();
                    return;
                end
            end
            if (cyc >= 100) begin
                chk("result_timeout", k, -1);
                return;
            end
            chk("latency", cyc, 17);
            chk("row", longint'(orow[d]), k / ow);
            chk("col", longint'(ocol[d]), k % ow);
            for (int n = 0; n < 4; n++)
                chk("lane", lane(d, n), exp_lane(d, k / ow, k % ow, n));
            if (k == stall_at) begin
                rdy[d] = 1'b0;
                for (int n = 0; n < 4; n++) snap[n] = lane(d, n);
                srow = longint'(orow[d]);
                scol = longint'(ocol[d]);
                repeat (5) begin
                    img_en[d]  = 1'b1;
                    flt_en[d]  = 1'b1;
                    ldat[d]    = 8'hAA;
                    start_v[d] = 1'b1;
                    tick();
                    chk("stall_valid", longint'(ov_v[d]), 1);
                    chk("stall_row", longint'(orow[d]), srow);
                    chk("stall_col", longint'(ocol[d]), scol);
                    for (int n = 0; n < 4; n++)
                        chk("stall_lane", lane(d, n), snap[n]);
                end
                img_en[d]  = 1'b0;
                flt_en[d]  = 1'b0;
                start_v[d] = 1'b0;
                rdy[d]     = 1'b1;
            end
            tick();
            dn += int'(done_v[d]);
        end
        chk("fin_done", longint'(done_v[d]), 1);
        chk("fin_valid", longint'(ov_v[d]), 0);
        chk("fin_busy", longint'(busy_v[d]), 1);
        tick();
        chk("idle_done", longint'(done_v[d]), 0);
        chk("idle_busy", longint'(busy_v[d]), 0);
        chk("done_pulses", dn, 1);
    endtask

    initial begin
        rst     = 1'b1;
        img_en  = '0;
        flt_en  = '0;
        start_v = '0;
        rdy     = 3'b111;
        ldat    = '0;
        repeat (3) tick();
        chk("reset_busy", longint'(busy_v[0]), 0);
        chk("reset_done", longint'(done_v[0]), 0);
        chk("reset_valid", longint'(ov_v[0]), 0);
        chk("reset_row", longint'(orow[0]), 0);
        chk("reset_col", longint'(ocol[0]), 0);
        chk("reset_lane3", lane(0, 3), 0);
        rst = 1'b0;
        tick();

        repeat (5) ld(0, 1'b1, 1'b1, 8'd1);
        repeat (251) ld(0, 1'b1, 1'b0, 8'd1);
        for (int i = 0; i < 64; i++) ld(0, 1'b0, 1'b1, 8'(i / 16 + 1));

        for (int p = 0; p < 256; p++) ld(1, 1'b1, 1'b0, 8'(p % 256));
        for (int i = 0; i < 64; i++) ld(1, 1'b0, 1'b1, i == 0 ? 8'd1 : 8'd0);

        repeat (256) ld(2, 1'b1, 1'b0, 8'd255);
        repeat (64) ld(2, 1'b0, 1'b1, 8'd255);

        run_pass(0, 3, -1);
        run_pass(0, -1, -1);
        run_pass(0, -1, 50);
        run_pass(0, -1, -1);
        run_pass(1, -1, -1);
        run_pass(2, 4, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/conv_engine.md
CONV_ENGINE -- requirements
Module: conv_engine

Interface
REQ-001 Parameter: IMG_W, 16, square input image side in pixels.
REQ-002 Parameter: K, 4, square filter side; K <= IMG_W.
REQ-003 Parameter: N_CH, 4, parallel filters/output channels (MAC lanes).
REQ-004 Parameter: DW, 8, pixel and weight width (unsigned).
REQ-005 Parameter: AW, 32, accumulator/result width per lane.
REQ-006 Parameter: STRIDE, 1, window step in both row and column.
REQ-007 The design SHALL run on one clock; reset is asynchronous and active-high.
REQ-008 clk  in  1  clock; all state changes on rising edge.
REQ-009 rst  in  1  asynchronous active-high reset.
REQ-010 load_img_en  in  1  write load_data into image buffer at current image pointer.
REQ-011 load_flt_en  in  1  write load_data into filter bank at current filter pointer.
REQ-012 load_data  in  DW  load word.
REQ-013 start  in  1  begin convolution pass; sampled only in IDLE.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse after final result is accepted.
REQ-016 out_valid  out  1  result available.
REQ-017 out_ready  in  1  consumer accepts result when out_valid & out_ready.
REQ-018 out_data  out  N_CH*AW  lane n result at bits [n*AW +: AW].
REQ-019 out_row, out_col  out  8 each  output position index of out_data.

Function
REQ-020 OW SHALL equal (IMG_W-K)/STRIDE+1 (floor); a pass produces OW*OW results, row-major.
REQ-021 Image load: raster order, pointer increments per accepted word, wraps to 0 after IMG_W*IMG_W words.
REQ-022 Filter load: filter 0 taps raster order, then filter 1, ...; pointer wraps to 0 after N_CH*K*K words.
REQ-023 load_img_en and load_flt_en both high SHALL write image only; filter pointer unchanged.
REQ-024 Loads while busy SHALL be ignored; pointers unchanged.
REQ-025 FSM states IDLE, MAC, OUT, FIN; IDLE->MAC on start; MAC->OUT after K*K cycles; OUT->MAC on handshake if positions remain, else OUT->FIN; FIN->IDLE after one cycle.
REQ-026 MAC: one tap per cycle; every lane adds pixel*weight (2*DW-bit product, zero-extended) to its accumulator, truncated modulo 2^AW.
REQ-027 Accumulators SHALL clear on entry to MAC.
REQ-028 out_valid SHALL rise on the (K*K+1)th rising edge after the edge that sampled start.
REQ-029 out_data, out_row, out_col SHALL hold stable while out_valid & !out_ready.
REQ-030 Position advance: out_col += 1 until OW-1, then out_col=0, out_row += 1; pixel address = (row*STRIDE+i)*IMG_W + col*STRIDE+j.
REQ-031 done SHALL be high exactly in FIN; out_valid low in FIN.
REQ-032 start while busy SHALL be ignored.
REQ-033 Image and filter storage SHALL be unmodified by a pass; repeated start reproduces identical results.

Reset
REQ-034 rst SHALL force IDLE, both load pointers, accumulators, position counters, busy, done, out_valid, out_data, out_row, out_col to 0, at any time including mid-pass.
REQ-035 Image and filter storage contents SHALL NOT require reset.

Verification
REQ-036 Defaults; image all 1; filter n all (n+1); start -> 169 results, lane n = 16*(n+1), positions (0,0)..(12,12), one done pulse.
REQ-037 out_ready low 5 cycles on result 3 -> out_data/out_row/out_col stable, no result lost or duplicated.
REQ-038 STRIDE=2, ramp image pixel=p%256, filter 0 single tap 1 at (0,0) -> 49 results, lane 0 = pixel at (2r,2c).
REQ-039 AW=16, image and weights 255 -> lane result 1040400 mod 65536 = 57360.
REQ-040 rst asserted mid-MAC at result 50 -> busy/out_valid 0 next cycle; new start gives full correct 169 results.
REQ-041 load_img_en+load_flt_en together, and loads/start while busy -> filter bank and pass unaffected, results match REQ-036.
